// File: rtl/calc_pkg.sv
// Shared op codes, FSM encoding and per-op latency for the sequential calculator.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Optional divider selected by CALC_DIV_EN.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Cycles spent in CALC for a legal, non-degenerate op; div-by-zero is
    // special-cased by the caller since it depends on operand data.
    function automatic int unsigned op_latency(input logic [1:0] op, input int unsigned w);
        if (op == OP_MUL) return w;
`ifdef CALC_DIV_EN
        if (op == OP_DIV) return w;
`endif
        return 1;
    endfunction

endpackage

// File: rtl/calc_iter_unit.sv
// Shared 2W-bit shift register and iteration counter for shift-add mul / restoring div.
// Latency: one bit per step, W steps; acc_nxt is the combinational value of the next step.
// Backpressure: none, steps whenever the owner asserts step. Div path built only with CALC_DIV_EN.
module calc_iter_unit
    import calc_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     step,
`ifdef CALC_DIV_EN
    input  logic                     is_div,
`endif
    input  logic [W-1:0]             ld_val,
    input  logic [W-1:0]             opnd,
    output logic [$clog2(W+1)-1:0]   cnt,
    output logic [2*W-1:0]           acc_nxt
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [2*W-1:0] acc;
    logic [W:0]     mul_sum;
`ifdef CALC_DIV_EN
    logic [W:0]     div_trial;
`endif

    // Mul: acc = {partial product, remaining multiplier}, add on LSB then shift right.
    // Div: acc = {remainder, dividend/quotient}, shift left and trial-subtract divisor.
    always_comb begin
        mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_nxt = {mul_sum, acc[W-1:1]};
`ifdef CALC_DIV_EN
        div_trial = acc[2*W-1:W-1] - {1'b0, opnd};
        if (is_div) begin
            if (!div_trial[W])
                acc_nxt = {div_trial[W-1:0], acc[W-2:0], 1'b1};
            else
                acc_nxt = {acc[2*W-2:0], 1'b0};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= {{W{1'b0}}, ld_val};
            cnt <= '0;
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/seq_calc.sv
// Multi-cycle add/sub/mul/div calculator with start/busy/done handshake (div needs CALC_DIV_EN).
// Latency: result one edge after start for add/sub/div0/illegal, W edges for mul/div.
// Backpressure: start ignored while busy; a start in the done cycle is accepted.
module seq_calc
    import calc_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     SW_X,
    input  logic [W-1:0]     SW_Y,
    input  logic [1:0]       SW_op_sel,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   LED_output_result,
    output logic             LED_carry_out,
    output logic             LED_overflow
);

    localparam int unsigned CW = $clog2(W + 1);

    state_t          state;
    logic [W-1:0]    x_q;
    logic [W-1:0]    y_q;
    logic [1:0]      op_q;

    logic            load;
    logic            last;
    logic            div_zero;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   lat_m1;
    logic [W-1:0]    ld_val;
    logic [W-1:0]    opnd;
    logic [2*W-1:0]  acc_nxt;

    logic [W:0]      add_sum;
    logic [W:0]      sub_diff;
    logic [2*W-1:0]  res_nxt;
    logic            carry_nxt;
    logic            ovf_nxt;

    assign load = start && (state != CALC);

`ifdef CALC_DIV_EN
    assign div_zero = (op_q == OP_DIV) && (y_q == '0);
    assign ld_val   = (SW_op_sel == OP_DIV) ? SW_X : SW_Y;
    assign opnd     = (op_q == OP_DIV) ? y_q : x_q;
`else
    assign div_zero = 1'b0;
    assign ld_val   = SW_Y;
    assign opnd     = x_q;
`endif

    assign lat_m1 = div_zero ? '0 : CW'(op_latency(op_q, W) - 1);
    assign last   = (cnt == lat_m1);

    calc_iter_unit #(.W(W)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (state == CALC),
`ifdef CALC_DIV_EN
        .is_div  (op_q == OP_DIV),
`endif
        .ld_val  (ld_val),
        .opnd    (opnd),
        .cnt     (cnt),
        .acc_nxt (acc_nxt)
    );

    assign add_sum  = {1'b0, x_q} + {1'b0, y_q};
    assign sub_diff = {1'b0, x_q} - {1'b0, y_q};

    always_comb begin
        res_nxt   = '0;
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
        case (op_q)
            OP_ADD: begin
                res_nxt   = {{W{1'b0}}, add_sum[W-1:0]};
                carry_nxt = add_sum[W];
                ovf_nxt   = (x_q[W-1] == y_q[W-1]) && (add_sum[W-1] != x_q[W-1]);
            end
            OP_SUB: begin
                res_nxt   = {{W{1'b0}}, sub_diff[W-1:0]};
                carry_nxt = sub_diff[W];
                ovf_nxt   = (x_q[W-1] != y_q[W-1]) && (sub_diff[W-1] != x_q[W-1]);
            end
            OP_MUL: res_nxt = acc_nxt;
            default: begin
`ifdef CALC_DIV_EN
                if (div_zero) begin
                    res_nxt = {x_q, {W{1'b1}}};
                    ovf_nxt = 1'b1;
                end else begin
                    res_nxt = acc_nxt;
                end
`else
                ovf_nxt = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            LED_output_result <= '0;
            LED_carry_out     <= 1'b0;
            LED_overflow      <= 1'b0;
            x_q               <= '0;
            y_q               <= '0;
            op_q              <= OP_ADD;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        x_q   <= SW_X;
                        y_q   <= SW_Y;
                        op_q  <= SW_op_sel;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (last) begin
                        state             <= FIN;
                        busy              <= 1'b0;
                        done              <= 1'b1;
                        LED_output_result <= res_nxt;
                        LED_carry_out     <= carry_nxt;
                        LED_overflow      <= ovf_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
